// File: rtl/dpll_decision_trail_if.sv
// Signal bundle between the DPLL decision/trail stage, the literal picker,
// the propagation unit and the search controller.
interface dpll_decision_trail_if #(
    parameter int WIDTH = 8,
    parameter int N     = 256
);
    logic [WIDTH-1:0] cand_val;
    logic             cand_valid;
    logic             pick_ena;
    logic             decide_req;
    logic             imp_valid;
    logic [WIDTH-1:0] imp_var;
    logic             imp_pol;
    logic             bt_req;
    logic [N-1:0]     lit_assigned;
    logic [N-1:0]     lit_value;
    logic [WIDTH-1:0] dec_level;
    logic             dec_done;
    logic [WIDTH-1:0] dec_var;
    logic             dec_pol;
    logic             all_assigned;
    logic             bt_done;
    logic             unsat;

    modport slave (
        input  cand_val, cand_valid, decide_req, imp_valid, imp_var, imp_pol, bt_req,
        output pick_ena, lit_assigned, lit_value, dec_level, dec_done, dec_var, dec_pol,
               all_assigned, bt_done, unsat
    );

    modport master (
        output cand_val, cand_valid, decide_req, imp_valid, imp_var, imp_pol, bt_req,
        input  pick_ena, lit_assigned, lit_value, dec_level, dec_done, dec_var, dec_pol,
               all_assigned, bt_done, unsat
    );
endinterface

// File: rtl/dpll_decision_trail.sv
// DPLL decision/trail stage: commits picker candidates, records implications and
// backtracks chronologically. Define PHASE_SAVE_EN to reuse saved phases as decision polarity.
module dpll_decision_trail #(
    parameter int WIDTH = 8,
    parameter int N     = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    dpll_decision_trail_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] FULL_CNT = WIDTH'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        BT_POP
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] trail_var  [N];
    logic             trail_dec  [N];
    logic             trail_flip [N];

    logic [WIDTH-1:0] sp;
    logic [WIDTH-1:0] assigned_cnt;
    logic [WIDTH-1:0] dec_level;
    logic [WIDTH-1:0] dec_var;
    logic [N-1:0]     lit_assigned;
    logic [N-1:0]     lit_value;
    logic             dec_pol;
    logic             dec_done;
    logic             bt_done;
    logic             unsat;
    logic             all_assigned;

    logic [WIDTH-1:0] top_idx;
    logic [WIDTH-1:0] top_var;
    logic             top_dec;
    logic             top_flip;
    logic             cand_ok;
    logic             imp_ok;
    logic             commit_pol;

    logic do_commit;
    logic do_imp;
    logic do_pop;
    logic do_flip;
    logic set_unsat;

    assign top_idx      = sp - ONE;
    assign top_var      = trail_var[top_idx];
    assign top_dec      = trail_dec[top_idx];
    assign top_flip     = trail_flip[top_idx];
    assign all_assigned = (assigned_cnt == FULL_CNT);

`ifdef PHASE_SAVE_EN
    logic [N-1:0] saved_phase;
    assign commit_pol = saved_phase[bus.cand_val];
`else
    assign commit_pol = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nx  = state;
        do_commit = 1'b0;
        do_imp    = 1'b0;
        do_pop    = 1'b0;
        do_flip   = 1'b0;
        set_unsat = 1'b0;
        cand_ok   = (bus.cand_val != '0) && !lit_assigned[bus.cand_val];
        imp_ok    = (bus.imp_var != '0) && !lit_assigned[bus.imp_var];

        case (state)
            IDLE: begin
                // bt_req > imp_valid > decide_req; losers are dropped, and unsat freezes everything
                if (!unsat) begin
                    if (bus.bt_req) begin
                        state_nx  = BT_POP;
                        set_unsat = (sp == '0);
                    end else if (bus.imp_valid) begin
                        do_imp = imp_ok;
                    end else if (bus.decide_req && !all_assigned) begin
                        state_nx = SEARCH;
                    end
                end
            end
            SEARCH: begin
                if (bus.cand_valid && cand_ok) begin
                    do_commit = 1'b1;
                    state_nx  = IDLE;
                end
            end
            BT_POP: begin
                if (sp == '0) begin
                    set_unsat = 1'b1;
                    state_nx  = IDLE;
                end else if (top_dec && !top_flip) begin
                    do_flip  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    do_pop = 1'b1;
                    if (sp == ONE) begin
                        set_unsat = 1'b1;
                        state_nx  = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: the trail is plain storage qualified by sp, so it is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_commit) begin
            trail_var[sp]  <= bus.cand_val;
            trail_dec[sp]  <= 1'b1;
            trail_flip[sp] <= 1'b0;
        end else if (do_imp) begin
            trail_var[sp]  <= bus.imp_var;
            trail_dec[sp]  <= 1'b0;
            trail_flip[sp] <= 1'b0;
        end else if (do_flip) begin
            trail_flip[top_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp           <= '0;
            assigned_cnt <= '0;
            dec_level    <= '0;
            dec_var      <= '0;
            dec_pol      <= 1'b0;
            lit_assigned <= '0;
            lit_value    <= '0;
            dec_done     <= 1'b0;
            bt_done      <= 1'b0;
            unsat        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update tied to values from before the edge.
            dec_done <= do_commit;
            bt_done  <= do_flip;
            if (set_unsat) unsat <= 1'b1;

            if (do_commit) begin
                lit_assigned[bus.cand_val] <= 1'b1;
                lit_value[bus.cand_val]    <= commit_pol;
                sp           <= sp + ONE;
                assigned_cnt <= assigned_cnt + ONE;
                dec_level    <= dec_level + ONE;
                dec_var      <= bus.cand_val;
                dec_pol      <= commit_pol;
            end

            if (do_imp) begin
                lit_assigned[bus.imp_var] <= 1'b1;
                lit_value[bus.imp_var]    <= bus.imp_pol;
                sp           <= sp + ONE;
                assigned_cnt <= assigned_cnt + ONE;
            end

            if (do_pop) begin
                lit_assigned[top_var] <= 1'b0;
                sp           <= sp - ONE;
                assigned_cnt <= assigned_cnt - ONE;
                if (top_dec) dec_level <= dec_level - ONE;
            end

            // The flipped decision keeps its level; only its value and the flip mark change
            if (do_flip) begin
                lit_value[top_var] <= ~lit_value[top_var];
                dec_var <= top_var;
                dec_pol <= ~lit_value[top_var];
            end
        end
    end

`ifdef PHASE_SAVE_EN
    always_ff @(posedge clk) begin
        if (rst)         saved_phase          <= '0;
        else if (do_pop) saved_phase[top_var] <= lit_value[top_var];
    end
`endif

    assign bus.pick_ena     = (state == SEARCH);
    assign bus.lit_assigned = lit_assigned;
    assign bus.lit_value    = lit_value;
    assign bus.dec_level    = dec_level;
    assign bus.dec_done     = dec_done;
    assign bus.dec_var      = dec_var;
    assign bus.dec_pol      = dec_pol;
    assign bus.all_assigned = all_assigned;
    assign bus.bt_done      = bt_done;
    assign bus.unsat        = unsat;
endmodule

// File: tb/tb_dpll_decision_trail.sv
// Randomized bench for dpll_decision_trail against a transaction-level trail model.
// Polarity expectations follow PHASE_SAVE_EN when the macro is defined for the build.
module tb_dpll_decision_trail;
    localparam int W = 4;
    localparam int N = 16;

    typedef struct {
        int v;
        bit dec;
        bit flip;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dpll_decision_trail_if #(.WIDTH(W), .N(N)) bus ();
    dpll_decision_trail #(.WIDTH(W), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    bit     m_asg   [N];
    bit     m_val   [N];
    bit     m_saved [N];
    entry_t m_trail [$];
    bit     m_unsat;
    int     m_dvar;
    bit     m_dpol;
    int     cand_q  [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] asg_vec();
        logic [63:0] r = '0;
        for (int i = 0; i < N; i++) r[i] = m_asg[i];
        return r;
    endfunction

    function automatic logic [63:0] val_vec();
        logic [63:0] r = '0;
        for (int i = 0; i < N; i++) r[i] = m_asg[i] & m_val[i];
        return r;
    endfunction

    function automatic int n_assigned();
        int n = 0;
        for (int i = 0; i < N; i++) n += int'(m_asg[i]);
        return n;
    endfunction

    // Decision level is simply the number of decisions currently on the trail
    function automatic int level();
        int n = 0;
        foreach (m_trail[i]) n += int'(m_trail[i].dec);
        return n;
    endfunction

    function automatic int first_free();
        for (int i = 1; i < N; i++) if (!m_asg[i]) return i;
        return 0;
    endfunction

    function automatic bit decision_pol(input int v);
`ifdef PHASE_SAVE_EN
        return m_saved[v];
`else
        return (v < 0);
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_asg[i]   = 1'b0;
            m_val[i]   = 1'b0;
            m_saved[i] = 1'b0;
        end
        m_trail.delete();
        cand_q.delete();
        m_unsat = 1'b0;
        m_dvar  = 0;
        m_dpol  = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "/assigned"}, 64'(bus.lit_assigned), asg_vec());
        check({tag, "/value"}, 64'(bus.lit_value & bus.lit_assigned), val_vec());
        check({tag, "/level"}, 64'(bus.dec_level), 64'(level()));
        check({tag, "/all_assigned"}, 64'(bus.all_assigned), 64'(n_assigned() == N - 1));
        check({tag, "/unsat"}, 64'(bus.unsat), 64'(m_unsat));
        check({tag, "/dec_var"}, 64'(bus.dec_var), 64'(m_dvar));
        check({tag, "/dec_pol"}, 64'(bus.dec_pol), 64'(m_dpol));
        check({tag, "/pick_ena_idle"}, 64'(bus.pick_ena), 64'd0);
    endtask

    task automatic drive_idle();
        bus.cand_val   = '0;
        bus.cand_valid = 1'b0;
        bus.decide_req = 1'b0;
        bus.imp_valid  = 1'b0;
        bus.imp_var    = '0;
        bus.imp_pol    = 1'b0;
        bus.bt_req     = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_clear();
        check_state(tag);
        check({tag, "/dec_done"}, 64'(bus.dec_done), 64'd0);
        check({tag, "/bt_done"}, 64'(bus.bt_done), 64'd0);
    endtask

    // Called after the decide_req edge; feeds candidates until the model sees a commit
    task automatic run_search(input string tag);
        bit done = 1'b0;
        bit v;
        bit good;
        int c;
        check({tag, "/pick_ena"}, 64'(bus.pick_ena), 64'd1);
        for (int t = 0; t < 60 && !done; t++) begin
            if (cand_q.size() > 0) begin
                c = cand_q.pop_front();
                v = 1'b1;
            end else if (t >= 40) begin
                c = first_free();
                v = 1'b1;
            end else begin
                c = int'($urandom_range(0, N - 1));
                v = ($urandom_range(0, 3) != 0);
            end
            bus.cand_val   = W'(c);
            bus.cand_valid = v;
            tick();
            bus.cand_valid = 1'b0;
            good = v && (c != 0) && !m_asg[c];
            check({tag, "/dec_done"}, 64'(bus.dec_done), 64'(good));
            if (good) begin
                m_val[c] = decision_pol(c);
                m_asg[c] = 1'b1;
                m_trail.push_back('{c, 1'b1, 1'b0});
                m_dvar = c;
                m_dpol = m_val[c];
                done   = 1'b1;
            end else begin
                check({tag, "/pick_ena_wait"}, 64'(bus.pick_ena), 64'd1);
            end
        end
        check_state(tag);
        tick();
        check({tag, "/dec_done_pulse"}, 64'(bus.dec_done), 64'd0);
    endtask

    // Called after the bt_req edge; model pops implied/flipped entries, then flips or goes unsat
    task automatic run_bt(input string tag);
        int k = 0;
        int cycles = 0;
        int exp_cycles;
        int top;
        bit exp_unsat;
        entry_t e;
        while (m_trail.size() > 0 &&
               !(m_trail[m_trail.size() - 1].dec && !m_trail[m_trail.size() - 1].flip)) begin
            e = m_trail.pop_back();
            m_asg[e.v]   = 1'b0;
            m_saved[e.v] = m_val[e.v];
            k++;
        end
        if (m_trail.size() > 0) begin
            top = m_trail.size() - 1;
            m_trail[top].flip = 1'b1;
            m_val[m_trail[top].v] = !m_val[m_trail[top].v];
            m_dvar     = m_trail[top].v;
            m_dpol     = m_val[m_trail[top].v];
            exp_unsat  = 1'b0;
            exp_cycles = k + 1;
        end else begin
            m_unsat    = 1'b1;
            exp_unsat  = 1'b1;
            exp_cycles = k;
        end
        while (!(exp_unsat ? bus.unsat : bus.bt_done) && cycles < 2 * N + 4) begin
            tick();
            cycles++;
        end
        check({tag, "/bt_cycles"}, 64'(cycles), 64'(exp_cycles));
        check_state(tag);
        tick();
        check({tag, "/bt_done_pulse"}, 64'(bus.bt_done), 64'd0);
    endtask

    task automatic request(input string tag, input bit bt, input bit imp, input bit dec,
                           input int iv, input bit ip);
        bus.bt_req     = bt;
        bus.imp_valid  = imp;
        bus.imp_var    = W'(iv);
        bus.imp_pol    = ip;
        bus.decide_req = dec;
        tick();
        drive_idle();
        if (m_unsat) begin
            check_state({tag, "/frozen"});
        end else if (bt) begin
            run_bt(tag);
        end else if (imp) begin
            if (iv != 0 && !m_asg[iv]) begin
                m_asg[iv] = 1'b1;
                m_val[iv] = ip;
                m_trail.push_back('{iv, 1'b0, 1'b0});
            end
            check_state(tag);
        end else if (dec && n_assigned() != N - 1) begin
            run_search(tag);
        end else begin
            check_state(tag);
        end
    endtask

    initial begin
        int r;
        drive_idle();
        do_reset("reset");

        // First decision on candidate 5
        cand_q.push_back(5);
        request("tp1", 1'b0, 1'b0, 1'b1, 0, 1'b0);
        check("tp1/lit5", 64'(bus.lit_assigned[5]), 64'd1);
        check("tp1/level1", 64'(bus.dec_level), 64'd1);

        // Already-assigned candidate is dropped, the next one commits
        cand_q.push_back(5);
        cand_q.push_back(9);
        request("tp2", 1'b0, 1'b0, 1'b1, 0, 1'b0);
        check("tp2/level2", 64'(bus.dec_level), 64'd2);
        check("tp2/dec_var9", 64'(bus.dec_var), 64'd9);

        // Decision 3, implication 7=1, backtrack pops 7 and flips 3
        do_reset("tp3_reset");
        cand_q.push_back(3);
        request("tp3_dec", 1'b0, 1'b0, 1'b1, 0, 1'b0);
        request("tp3_imp", 1'b0, 1'b1, 1'b0, 7, 1'b1);
        request("tp3_bt", 1'b1, 1'b0, 1'b0, 0, 1'b0);
        check("tp3/lit7_clear", 64'(bus.lit_assigned[7]), 64'd0);
        check("tp3/val3_flipped", 64'(bus.lit_value[3]), 64'd1);
        check("tp3/level1", 64'(bus.dec_level), 64'd1);

        // Flipped decision alone on the trail: backtrack empties it and goes unsat
        request("tp4_bt", 1'b1, 1'b0, 1'b0, 0, 1'b0);
        check("tp4/unsat", 64'(bus.unsat), 64'd1);
        request("tp4_dec_ignored", 1'b0, 1'b0, 1'b1, 0, 1'b0);
        request("tp4_imp_ignored", 1'b0, 1'b1, 1'b0, 6, 1'b1);

        // Fill every variable, then check the all_assigned boundary and request priority
        do_reset("tp5_reset");
        cand_q.push_back(1);
        request("tp5_dec", 1'b0, 1'b0, 1'b1, 0, 1'b0);
        for (int v = 2; v < N - 1; v++)
            request("tp5_imp", 1'b0, 1'b1, 1'b0, v, bit'(v % 2));
        request("tp5_imp_over_dec", 1'b0, 1'b1, 1'b1, N - 1, 1'b1);
        check("tp5/all_assigned", 64'(bus.all_assigned), 64'd1);
        request("tp5_dec_ignored", 1'b0, 1'b0, 1'b1, 0, 1'b0);
        request("tp5_bt_over_dec", 1'b1, 1'b0, 1'b1, 0, 1'b0);
        check("tp5/level_after_bt", 64'(bus.dec_level), 64'd1);

        // Phase saving: 4=1 by implication, backtrack past it, then decide on 4
        do_reset("tp6_reset");
        cand_q.push_back(2);
        request("tp6_dec", 1'b0, 1'b0, 1'b1, 0, 1'b0);
        request("tp6_imp", 1'b0, 1'b1, 1'b0, 4, 1'b1);
        request("tp6_bt", 1'b1, 1'b0, 1'b0, 0, 1'b0);
        cand_q.push_back(4);
        request("tp6_redec", 1'b0, 1'b0, 1'b1, 0, 1'b0);
`ifdef PHASE_SAVE_EN
        check("tp6/val4_saved", 64'(bus.lit_value[4]), 64'd1);
`else
        check("tp6/val4_default", 64'(bus.lit_value[4]), 64'd0);
`endif

        // Reset in the middle of a search drops the pending commit
        do_reset("rst_search_reset");
        bus.decide_req = 1'b1;
        tick();
        bus.decide_req = 1'b0;
        check("rst_search/pick_ena", 64'(bus.pick_ena), 64'd1);
        bus.cand_val   = W'(6);
        bus.cand_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_idle();
        model_clear();
        check_state("rst_search");
        check("rst_search/dec_done", 64'(bus.dec_done), 64'd0);

        for (int i = 0; i < 400; i++) begin
            if (m_unsat && $urandom_range(0, 1) == 1) do_reset("rand_reset");
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2: request("rand_dec", 1'b0, 1'b0, 1'b1, 0, 1'b0);
                3, 4, 5: request("rand_imp", 1'b0, 1'b1, 1'b0,
                                 int'($urandom_range(0, N - 1)), bit'($urandom_range(0, 1)));
                6, 7:    request("rand_bt", 1'b1, 1'b0, 1'b0, 0, 1'b0);
                8:       request("rand_mix", bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                                 1'b1, int'($urandom_range(0, N - 1)), bit'($urandom_range(0, 1)));
                default: request("rand_nop", 1'b0, 1'b0, 1'b0, 0, 1'b0);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
